// File: rtl/noc_bus_arbiter.sv
// Round-robin packet arbiter that merges N_REQ NoC requesters onto one memory port.
// A packet keeps the bus until its requester drops req_bo; overlong packets are flushed.
module noc_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                        fclk,
  input  logic                        rst,
  input  logic [N_REQ-1:0][31:0][7:0] req_dat,
  input  logic [N_REQ-1:0][5:0]       req_bp,
  input  logic [N_REQ-1:0]            req_bo,
  output logic [N_REQ-1:0]            req_rdy,
  output logic [31:0][7:0]            oup_dat,
  output logic [5:0]                  oup_bp,
  output logic                        oup_bo,
  input  logic                        oup_rdy,
  output logic [N_REQ-1:0]            grant,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FLUSH
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  pick, gnext;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_d;
  logic           to_d;
  logic           found;
  logic           g_bo;
  logic           at_max;

  // First requester with req_bo set, scanning from rr_q with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_bo[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign gnext  = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign g_bo   = req_bo[gidx_q];
  assign at_max = (cnt_q == CW'(MAX_BEATS));

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    to_d    = timeout_err & ~err_clr;
    req_rdy = '0;
    oup_dat = '0;
    oup_bp  = '0;
    oup_bo  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          state_d = BUSY;
          gidx_d  = pick;
          grant_d = N_REQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (g_bo && at_max) begin
          // Beat budget exhausted: nothing more is forwarded.
          to_d    = 1'b1;
          state_d = FLUSH;
        end else begin
          oup_dat         = req_dat[gidx_q];
          oup_bp          = req_bp[gidx_q];
          oup_bo          = g_bo;
          req_rdy[gidx_q] = g_bo & oup_rdy;
          if (!g_bo) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = gnext;
          end else if (oup_rdy && !at_max) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        req_rdy[gidx_q] = g_bo;
        if (!g_bo) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = gnext;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      grant       <= grant_d;
      timeout_err <= to_d;
    end
  end

endmodule

// File: tb/tb_noc_bus_arbiter.sv
// Directed bench for noc_bus_arbiter with MAX_BEATS=4.
// Inputs change after the falling edge; outputs are sampled 1ns later.
module tb_noc_bus_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic                    fclk = 1'b0;
  logic                    rst;
  logic [N-1:0][31:0][7:0] req_dat;
  logic [N-1:0][5:0]       req_bp;
  logic [N-1:0]            req_bo;
  logic [N-1:0]            req_rdy;
  logic [31:0][7:0]        oup_dat;
  logic [5:0]              oup_bp;
  logic                    oup_bo;
  logic                    oup_rdy;
  logic [N-1:0]            grant;
  logic                    timeout_err;
  logic                    err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  noc_bus_arbiter #(.N_REQ(N), .MAX_BEATS(MB)) dut (
    .fclk        (fclk),
    .rst         (rst),
    .req_dat     (req_dat),
    .req_bp      (req_bp),
    .req_bo      (req_bo),
    .req_rdy     (req_rdy),
    .oup_dat     (oup_dat),
    .oup_bp      (oup_bp),
    .oup_bo      (oup_bo),
    .oup_rdy     (oup_rdy),
    .grant       (grant),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int r, input int b);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(r * 256 + b);
    return {8{w}};
  endfunction

  initial begin
    rst     = 1'b0;
    oup_rdy = 1'b1;
    err_clr = 1'b0;
    req_bo  = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_dat[i] = pat(i, 0);
      req_bp[i]  = 6'(i + 1);
    end
    #1;
    check("rst_grant", grant, 0);
    check("rst_rdy", req_rdy, 0);
    check("rst_bo", oup_bo, 0);
    check("rst_dat", oup_dat, 0);
    check("rst_bp", oup_bp, 0);
    check("rst_to", timeout_err, 0);
    @(negedge fclk);
    rst = 1'b1;

    // all requesters busy: round-robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      @(negedge fclk);
      req_dat[g] = pat(g, 0);
      #1;
      check("rr_grant", grant, 1 << g);
      check("rr_rdy0", req_rdy, 1 << g);
      check("rr_dat0", oup_dat, pat(g, 0));
      check("rr_bp0", oup_bp, g + 1);
      @(negedge fclk);
      req_dat[g] = pat(g, 1);
      #1;
      check("rr_rdy1", req_rdy, 1 << g);
      check("rr_dat1", oup_dat, pat(g, 1));
      @(negedge fclk);
      req_bo[g] = 1'b0;
      #1;
      check("rr_drop_rdy", req_rdy, 0);
      check("rr_drop_grant", grant, 1 << g);
      @(negedge fclk);
      if (k < 4) req_bo[g] = 1'b1;
      else req_bo = '0;
      #1;
      check("rr_idle", grant, 0);
    end

    // single requester 1, three beats
    @(negedge fclk);
    req_bo[1]  = 1'b1;
    req_dat[1] = pat(1, 0);
    #1;
    check("s1_lat", grant, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge fclk);
      req_dat[1] = pat(1, b);
      req_bp[1]  = (b == 2) ? 6'd45 : 6'(b + 30);
      #1;
      check("s1_grant", grant, 4'b0010);
      check("s1_rdy", req_rdy, 4'b0010);
      check("s1_bo", oup_bo, 1);
      check("s1_dat", oup_dat, pat(1, b));
      check("s1_bp", oup_bp, (b == 2) ? 45 : b + 30);
    end
    @(negedge fclk);
    req_bo[1] = 1'b0;
    #1;
    check("s1_end_rdy", req_rdy, 0);
    check("s1_end_bo", oup_bo, 0);
    @(negedge fclk);
    req_bo = 4'b1010;
    #1;
    check("s1_idle", grant, 0);
    @(negedge fclk);
    req_bo = '0;
    #1;
    check("s1_rrptr", grant, 4'b1000);
    @(negedge fclk);
    req_bo[2] = 1'b1;
    req_dat[2] = pat(2, 0);
    #1;
    check("s3_idle", grant, 0);

    // requester 2 with a 5-cycle downstream stall
    @(negedge fclk);
    #1;
    check("st_grant", grant, 4'b0100);
    check("st_rdy0", req_rdy, 4'b0100);
    @(negedge fclk);
    req_dat[2] = pat(2, 1);
    oup_rdy    = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge fclk);
      #1;
      check("st_hold_rdy", req_rdy, 0);
      check("st_hold_dat", oup_dat, pat(2, 1));
      check("st_hold_grant", grant, 4'b0100);
      check("st_hold_bo", oup_bo, 1);
    end
    for (int b = 1; b < 4; b++) begin
      @(negedge fclk);
      oup_rdy    = 1'b1;
      req_dat[2] = pat(2, b);
      #1;
      check("st_rdy", req_rdy, 4'b0100);
      check("st_dat", oup_dat, pat(2, b));
    end
    @(negedge fclk);
    req_bo[2] = 1'b0;
    #1;
    check("st_end_rdy", req_rdy, 0);
    @(negedge fclk);
    req_bo[0] = 1'b1;
    #1;
    check("st_idle", grant, 0);
    check("st_no_to", timeout_err, 0);

    // requester 0 overruns MAX_BEATS by 3 beats
    for (int b = 0; b < 4; b++) begin
      @(negedge fclk);
      req_dat[0] = pat(0, b);
      #1;
      check("to_grant", grant, 4'b0001);
      check("to_rdy", req_rdy, 4'b0001);
      check("to_bo", oup_bo, 1);
      check("to_dat", oup_dat, pat(0, b));
    end
    @(negedge fclk);
    req_dat[0] = pat(0, 4);
    err_clr    = 1'b1;
    #1;
    check("to_cut_bo", oup_bo, 0);
    check("to_cut_rdy", req_rdy, 0);
    check("to_cut_dat", oup_dat, 0);
    check("to_pre", timeout_err, 0);
    for (int b = 4; b < 7; b++) begin
      @(negedge fclk);
      err_clr    = 1'b0;
      req_dat[0] = pat(0, b);
      oup_rdy    = (b != 5);
      #1;
      check("fl_to", timeout_err, 1);
      check("fl_bo", oup_bo, 0);
      check("fl_dat", oup_dat, 0);
      check("fl_rdy", req_rdy, 4'b0001);
      check("fl_grant", grant, 4'b0001);
    end
    @(negedge fclk);
    req_bo[0] = 1'b0;
    oup_rdy   = 1'b1;
    #1;
    check("fl_end_rdy", req_rdy, 0);
    @(negedge fclk);
    #1;
    check("fl_idle", grant, 0);
    check("fl_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge fclk);
    err_clr   = 1'b0;
    req_bo[2] = 1'b1;
    req_dat[2] = pat(2, 0);
    #1;
    check("clr", timeout_err, 0);

    // reset during the second beat of a packet
    @(negedge fclk);
    #1;
    check("rs_grant", grant, 4'b0100);
    @(negedge fclk);
    req_dat[2] = pat(2, 1);
    #1;
    check("rs_bo_pre", oup_bo, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_grant0", grant, 0);
    check("rs_rdy0", req_rdy, 0);
    check("rs_bo0", oup_bo, 0);
    check("rs_dat0", oup_dat, 0);
    check("rs_bp0", oup_bp, 0);
    @(negedge fclk);
    req_bo = 4'b1001;
    rst    = 1'b1;
    @(negedge fclk);
    #1;
    check("rs_restart", grant, 4'b0001);
    req_bo = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_bus_arbiter.md
NOC_BUS_ARBITER -- requirements
Module: noc_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of NoC bus requesters (2..8).
REQ-002 Parameter MAX_BEATS, default 16, maximum accepted beats per packet before forced release.
REQ-003 fclk  input  1  fabric clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_dat  input  [N_REQ-1:0][31:0][7:0]  per-requester 32-byte beat data.
REQ-006 req_bp  input  [N_REQ-1:0][5:0]  per-requester bytes-present count for the beat.
REQ-007 req_bo  input  [N_REQ-1:0]  per-requester bus-occupied; high for every beat of a packet.
REQ-008 req_rdy  output  [N_REQ-1:0]  per-requester beat-accepted strobe.
REQ-009 oup_dat  output  [31:0][7:0]  beat data toward the memory interface.
REQ-010 oup_bp  output  6  bytes-present toward the memory interface.
REQ-011 oup_bo  output  1  bus-occupied toward the memory interface.
REQ-012 oup_rdy  input  1  downstream can accept the current beat.
REQ-013 grant  output  [N_REQ-1:0]  one-hot owner, all-zero when idle.
REQ-014 timeout_err  output  1  sticky, MAX_BEATS exceeded.
REQ-015 err_clr  input  1  clears timeout_err.

Function
REQ-016 Packet = contiguous run of cycles with req_bo[i]=1; a requester drops req_bo for at least one cycle between packets.
REQ-017 A beat transfers in a cycle where state=BUSY, grant[i]=1, req_bo[i]=1, oup_rdy=1.
REQ-018 States IDLE, BUSY, FLUSH; encoding free.
REQ-019 IDLE: if any req_bo set, register grant to the first set requester at or after rr_ptr (wrapping N_REQ-1 -> 0), clear beat counter, go BUSY; 1-cycle arbitration latency.
REQ-020 IDLE with no req_bo: stay IDLE, grant=0.
REQ-021 BUSY: oup_dat/oup_bp = granted requester's inputs, oup_bo = req_bo[g]; req_rdy[g] = req_bo[g] & oup_rdy; all other req_rdy=0; combinational paths.
REQ-022 BUSY: oup_rdy=0 holds all state; stalls do not advance beat counter.
REQ-023 BUSY, req_bo[g]=0 sampled: next state IDLE, grant=0, rr_ptr=g+1 mod N_REQ.
REQ-024 BUSY: beat counter width clog2(MAX_BEATS+1), increments per transferred beat, saturates.
REQ-025 BUSY, counter = MAX_BEATS and req_bo[g]=1: set timeout_err, go FLUSH; no further beat forwarded.
REQ-026 FLUSH: oup_bo=0, req_rdy[g]=req_bo[g] (beats discarded regardless of oup_rdy); on req_bo[g]=0 go IDLE, rr_ptr=g+1.
REQ-027 IDLE and FLUSH: oup_dat=0, oup_bp=0, oup_bo=0.
REQ-028 req_bo of non-granted requesters ignored until next IDLE decision; no mid-packet switch.
REQ-029 req_bp forwarded unchanged, values >32 not checked.
REQ-030 timeout_err set and err_clr same cycle: set wins.
REQ-031 grant is always one-hot or zero.

Reset
REQ-032 rst=0 asynchronously forces state IDLE, grant=0, rr_ptr=0, counter=0, timeout_err=0, req_rdy=0, oup_bo=0, oup_dat=0, oup_bp=0.
REQ-033 Reset mid-packet abandons the packet; after release, arbitration restarts from requester 0.
REQ-034 First grant possible on first fclk edge after rst rises.

Verification
REQ-035 Single requester 1 sends 3 beats, oup_rdy=1 -> grant=0010 one cycle after req_bo, 3 beats out with bp/data matching, IDLE after req_bo drops, rr_ptr=2.
REQ-036 All four req_bo high continuously from reset, 2-beat packets -> grants in order 0,1,2,3,0, each with one idle cycle between.
REQ-037 Granted requester 2, oup_rdy low 5 cycles mid-packet -> data held, req_rdy[2]=0, counter unchanged, no grant change.
REQ-038 MAX_BEATS=4, requester 0 holds req_bo for 7 beats -> 4 beats forwarded, timeout_err=1, remaining 3 absorbed with oup_bo=0, then IDLE; err_clr clears flag.
REQ-039 rst asserted during beat 2 of a packet -> all outputs 0 immediately; after release, requester 0 wins if requesters 0 and 3 both request.
REQ-040 err_clr asserted in the cycle timeout_err sets -> timeout_err=1.
